// File: rtl/cmp_imm_pipe.sv
// cmp_imm_pipe: compares each valid token against immediate I using a runtime-selected relation.
// Latency: DEPTH enabled cycles from presentation to R_OUT/D_OUT; one token per enabled cycle.
// Backpressure: none; EN=0 freezes the whole pipe and a token presented then is not consumed.
module cmp_imm_pipe #(
    parameter int N      = 16,
    parameter int I      = 1,
    parameter int SIGNED = 0,
    parameter int DEPTH  = 1,
    parameter int CW     = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          CLR,
    input  logic          R_IN,
    input  logic [N-1:0]  D_IN,
    input  logic [2:0]    OP,
    output logic          R_OUT,
    output logic [N-1:0]  D_OUT,
    output logic [CW-1:0] HIT_CNT
);

    localparam logic [N-1:0] IMM = N'(I);

    logic             w_eq;
    logic             w_lt;
    logic             w_res;
    logic             w_hit;
    logic [DEPTH-1:0] w_v_nxt;
    logic [DEPTH-1:0] w_r_nxt;
    logic [DEPTH-1:0] r_v;
    logic [DEPTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;

    always_comb begin
        w_eq = (D_IN == IMM);
        if (SIGNED != 0) begin
            w_lt = ($signed(D_IN) < $signed(IMM));
        end else begin
            w_lt = (D_IN < IMM);
        end
    end

    always_comb begin
        w_res = 1'b0;
        case (OP)
            3'd0:    w_res = w_eq;
            3'd1:    w_res = ~w_eq;
            3'd2:    w_res = w_lt;
            3'd3:    w_res = w_lt | w_eq;
            3'd4:    w_res = ~(w_lt | w_eq);
            3'd5:    w_res = ~w_lt;
            3'd6:    w_res = 1'b0;
            default: w_res = 1'b1;
        endcase
    end

    // A bubble leaves the stage-0 result untouched so D_OUT can keep the last result.
    generate
        if (DEPTH == 1) begin : g_single
            assign w_v_nxt = R_IN;
            assign w_r_nxt = R_IN ? w_res : r_r[0];
            assign w_hit   = R_IN & w_res;
        end else begin : g_multi
            assign w_v_nxt = {r_v[DEPTH-2:0], R_IN};
            assign w_r_nxt = {r_r[DEPTH-2:0], (R_IN ? w_res : r_r[0])};
            assign w_hit   = r_v[DEPTH-2] & r_r[DEPTH-2];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_v <= '0;
            r_r <= '0;
        end else if (EN) begin
            r_v <= w_v_nxt;
            r_r <= w_r_nxt;
        end
    end

    // Counts on the edge a true token lands in the last stage; clear wins even when disabled.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt <= '0;
        end else if (CLR) begin
            r_cnt <= '0;
        end else if (EN && w_hit && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign R_OUT   = r_v[DEPTH-1];
    assign D_OUT   = N'(r_r[DEPTH-1]);
    assign HIT_CNT = r_cnt;

endmodule

// File: doc/cmp_imm_pipe.md
# cmp_imm_pipe

Parametrised compare-against-immediate unit for the dataflow operator library, succeeding the single-mode equality-immediate operator. Each valid input token is compared with the constant `I` using a runtime-selected relational operation, with signed or unsigned arithmetic. The 0/1 result travels through a stallable pipeline of `DEPTH` stages. A saturating hit counter reports how many true results have left the block. It sits between a producer and consumer operator on the same `R_*`/`D_*` token interface as the other operators.

## Interface
- `N`, 16, data width of `D_IN`/`D_OUT`
- `I`, 1, immediate operand; truncated to `N` bits
- `SIGNED`, 0, 1 = two's-complement compare of `D_IN` and `I`, 0 = unsigned
- `DEPTH`, 1, pipeline stages, legal range 1..4
- `CW`, 16, width of `HIT_CNT`
- `CLK`  input  1  clock, all state on rising edge
- `RST`  input  1  reset, asynchronous, active-low; asserted when 0
- `EN`  input  1  global enable; 0 freezes all pipeline state
- `CLR`  input  1  synchronous clear of `HIT_CNT`
- `R_IN`  input  1  input token valid
- `D_IN`  input  N  input operand
- `OP`  input  3  operation, sampled with the token: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6 FALSE, 7 TRUE
- `R_OUT`  output  1  output token valid (last stage)
- `D_OUT`  output  N  result, zero-extended: 1 = true, 0 = false
- `HIT_CNT`  output  CW  count of emitted true results, saturating

## Operation
- Comparison is `D_IN <op> I`. Examples: LT true when `D_IN < I`; GE true when `D_IN >= I`.
- Arithmetic:
  - With `SIGNED=1`, bit N-1 of both operands is the sign.
  - With `SIGNED=0`, both operands are unsigned N-bit.
  - EQ and NE are mode-independent.
  - FALSE and TRUE ignore `D_IN`.
- Stage k holds a valid bit `v[k]` and a 1-bit result `r[k]`; stage 0 is fed by the comparator.
- Stage update on a rising edge with `EN=1`:
  - Stage 0: `v[0] <= R_IN`.
  - Stage 0 with `R_IN=1`: `r[0] <=` comparator result.
  - Stage 0 with `R_IN=0`: `r[0]` holds its previous value (bubble).
  - Stage k>0: `v[k] <= v[k-1]`, `r[k] <= r[k-1]`.
- With `EN=0`, all `v` and `r` hold; no token is accepted or lost.
- Outputs: `R_OUT = v[DEPTH-1]`; `D_OUT = {N-1 zeros, r[DEPTH-1]}`.
- No backpressure port: the producer must treat a token presented with `EN=0` as not consumed.
- `HIT_CNT` priority, per rising edge:
  1. `CLR=1`: counter becomes 0, regardless of `EN`.
  2. Else, with `EN=1`, `v[DEPTH-2]=1` and `r[DEPTH-2]=1`: counter +1, saturating at 2^CW-1. This condition means a true token enters the last stage on this edge; for `DEPTH=1`, use the `R_IN`/comparator values instead.
  3. Otherwise the counter holds.
- Net effect: `HIT_CNT` increments on the same edge where `R_OUT`/`D_OUT` first show that true token.

## Timing
- Reset (`RST=0`), immediate and asynchronous:
  - All `v`, `r` and `HIT_CNT` go to 0.
  - `R_OUT=0`, `D_OUT=0`, `HIT_CNT=0`.
  - In-flight tokens are dropped.
- Reset release: the first edge with `RST=1` behaves as normal operation.
- Latency: a token accepted on edge t appears on `R_OUT`/`D_OUT` after `DEPTH` enabled edges.
  - With `EN` held high, it is visible from edge t+DEPTH-1 until the next edge, i.e. `DEPTH` cycles after presentation.
  - Disabled edges add no progress.
- Throughput: one token per enabled cycle; back-to-back tokens emerge back-to-back.
- After a token leaves, `D_OUT` keeps the last result while `R_OUT=0`, until the next valid token reaches the last stage.
- Boundary cases:
  - `CLR` together with an increment condition: the counter reads 0 after the edge (increment lost).
  - Counter at 2^CW-1 stays there.
  - `OP` changes while `R_IN=0` have no effect.

## Test plan
- Reset: drive `RST=0` mid-stream with `DEPTH=3` and tokens in flight -> `R_OUT`, `D_OUT`, `HIT_CNT` go to 0 without a clock edge; after release, no stale token appears.
- Signed LT with `N=8`, `I=1`, `SIGNED=1`, `OP=2`: tokens 0x00, 0xFF, 0x01, 0x7F -> results 1, 1, 0, 0.
  - Same tokens with `SIGNED=0` -> 1, 0, 0, 0.
- Latency, `DEPTH=4`, `EN=1`, one-cycle token at cycle 0 -> `R_OUT` high exactly during cycle 4, low otherwise.
- Stall, `DEPTH=2`, back-to-back tokens 5, 1, 1 with `OP=0`, `I=1`, `EN` low for 3 cycles mid-stream -> outputs 0, 1, 1 in order; none lost or duplicated; `R_OUT` frozen during the stall.
- Counter with `CW=2`, `OP=7`, 5 tokens -> `HIT_CNT` 1, 2, 3, 3, 3.
  - Then `CLR` asserted on the edge a sixth true token reaches the last stage -> `HIT_CNT=0`.
- Operation sweep over all 8 `OP` values against `I=1` with `D_IN` = 0, 1, 2 -> EQ 0,1,0; NE 1,0,1; LT 1,0,0; LE 1,1,0; GT 0,0,1; GE 0,1,1; FALSE 0,0,0; TRUE 1,1,1.
